// File: rtl/par_ser_ch_tx_pkg.sv
// Shared receiver/transmitter definitions for the parallel/serial complex
// channel blocks: default widths and depth, the packed complex word and the
// streaming FSM state encoding.
package par_ser_ch_tx_pkg;

  localparam int CH_DATA_WIDTH        = 16;
  localparam int CH_DOUBLE_DATA_WIDTH = 32;
  localparam int CH_DEPTH             = 13;

  // Packed complex sample: real part in the upper half, imaginary in the lower.
  typedef struct packed {
    logic signed [CH_DATA_WIDTH-1:0] re;
    logic signed [CH_DATA_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/par_ser_ch_tx.sv
// Parallel-to-serial complex channel transmitter.
// Captures a whole frame of DEPTH complex words in one cycle and plays it out
// one word per accepted beat, index 0 first.
//
// Handshake: a downstream beat happens on a rising edge where o_valid and
// i_ready are both high; o_data/o_last hold while i_ready is low. Upstream, a
// frame is taken on a rising edge where i_load and o_in_ready are both high.
// o_in_ready is high in IDLE and, combinationally from i_ready, during the
// final beat of a frame, so a new frame can follow with no o_valid gap.
module par_ser_ch_tx
  import par_ser_ch_tx_pkg::*;
#(
  parameter int DATA_WIDTH        = CH_DATA_WIDTH,
  parameter int DOUBLE_DATA_WIDTH = CH_DOUBLE_DATA_WIDTH,
  parameter int DEPTH             = CH_DEPTH
) (
  input  logic                                     clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_load,
  input  logic [DEPTH-1:0][DOUBLE_DATA_WIDTH-1:0]  i_data,
  output logic                                     o_in_ready,
  output logic signed [DOUBLE_DATA_WIDTH-1:0]      o_data,
  output logic                                     o_valid,
  input  logic                                     i_ready,
  output logic                                     o_last,
  output logic                                     o_done,
  output logic [0:0]                               o_dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [0:0] IDLE   = ST_IDLE;
  localparam logic [0:0] STREAM = ST_STREAM;

  logic [0:0]                              state;
  logic [IDX_W-1:0]                        idx;
  logic [DEPTH-1:0][DOUBLE_DATA_WIDTH-1:0] frame_q;

  logic                         beat;
  logic                         at_last;
  logic                         final_beat;
  logic                         load_acc;
  logic [DOUBLE_DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0]        cur_re;
  logic [DATA_WIDTH-1:0]        cur_im;

  // Handshake decode and output view of the current word.
  always_comb begin
    o_valid    = (state == STREAM);
    at_last    = (idx == LAST_IDX);
    beat       = o_valid && i_ready;
    final_beat = beat && at_last;
    o_in_ready = (state == IDLE) || final_beat;
    load_acc   = i_load && o_in_ready;
    o_last     = o_valid && at_last;

    cur_word = frame_q[idx];
    cur_re   = cur_word[DOUBLE_DATA_WIDTH-1 -: DATA_WIDTH];
    cur_im   = cur_word[DATA_WIDTH-1:0];
    // Pure pass-through; gated so the bus reads zero whenever nothing is offered.
    o_data   = o_valid ? {cur_re, cur_im} : '0;

    o_dbg_state = state;
  end

  // FSM, word index, frame buffer and done pulse.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      frame_q <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= final_beat;
      if (load_acc) begin
        // Also covers a load coinciding with the final beat: restart at word 0.
        frame_q <= i_data;
        idx     <= '0;
        state   <= STREAM;
      end else if (final_beat) begin
        state <= IDLE;
        idx   <= '0;
      end else if (beat && !at_last) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_par_ser_ch_tx.sv
// Directed bench for par_ser_ch_tx: frame playout, back-pressure, back-to-back
// frames, ignored loads, reset abort and signed pass-through.
module tb_par_ser_ch_tx;

  localparam int DEPTH = 13;
  localparam int W     = 32;

  typedef logic [DEPTH-1:0][W-1:0] frame_t;

  logic                clk = 1'b0;
  logic                i_rst_n;
  logic                i_load;
  logic                i_ready;
  frame_t              i_data;
  logic                o_in_ready;
  logic signed [W-1:0] o_data;
  logic                o_valid;
  logic                o_last;
  logic                o_done;
  logic [0:0]          o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  frame_t frm_a, frm_b, frm_c, frm_s;

  // clock / reset block
  always #5 clk = ~clk;

  par_ser_ch_tx dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_load      (i_load),
    .i_data      (i_data),
    .o_in_ready  (o_in_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_last      (o_last),
    .o_done      (o_done),
    .o_dbg_state (o_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drivers change inputs 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a frame from IDLE; returns in the first streaming cycle.
  task automatic start_load(input string tag, input frame_t f);
    i_load  = 1'b1;
    i_data  = f;
    i_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_rdy"},   32'(o_in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(o_valid),    32'd0);
    next_cycle();
    i_load = 1'b0;
  endtask

  // Check words from..upto-1 with i_ready held high, one per cycle.
  task automatic run_words(input string tag, input frame_t f, input int from, input int upto);
    i_ready = 1'b1;
    for (int i = from; i < upto; i++) begin
      @(negedge clk);
      check({tag, "_valid"}, 32'(o_valid),    32'd1);
      check({tag, "_data"},  o_data,          f[i]);
      check({tag, "_last"},  32'(o_last),     32'(i == DEPTH - 1));
      check({tag, "_rdy"},   32'(o_in_ready), 32'(i == DEPTH - 1));
      check({tag, "_done"},  32'(o_done),     32'd0);
      next_cycle();
    end
  endtask

  // Cycle right after the final beat: done pulse, back in IDLE.
  task automatic check_done(input string tag);
    @(negedge clk);
    check({tag, "_done_hi"},  32'(o_done),  32'd1);
    check({tag, "_done_vld"}, 32'(o_valid), 32'd0);
    next_cycle();
  endtask

  initial begin
    int k;
    int cyc;

    for (int i = 0; i < DEPTH; i++) begin
      frm_a[i] = 32'((i + 1) << 16);
      frm_b[i] = 32'hB000_0000 | 32'(i);
      frm_c[i] = 32'hC0C0_0000 | 32'(i * 3);
      frm_s[i] = 32'(i) * 32'h0001_0001;
    end
    frm_s[0] = 32'h8000_FFFF;
    frm_s[1] = 32'h7FFF_0001;

    i_rst_n = 1'b0;
    i_load  = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    #2;
    check("rst_valid", 32'(o_valid),    32'd0);
    check("rst_last",  32'(o_last),     32'd0);
    check("rst_done",  32'(o_done),     32'd0);
    check("rst_data",  o_data,          32'd0);
    check("rst_rdy",   32'(o_in_ready), 32'd1);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    next_cycle();
    next_cycle();
    i_rst_n = 1'b1;

    // Basic frame, i_ready held high: valid on cycles 1..13, done on 14.
    start_load("a", frm_a);
    run_words("a", frm_a, 0, DEPTH);
    check_done("a");
    @(negedge clk);
    check("a_done_lo", 32'(o_done), 32'd0);
    next_cycle();

    // Back-pressure: i_ready 1,0,1,0...; each word held while low.
    start_load("c", frm_c);
    k   = 0;
    cyc = 0;
    while (k < DEPTH && cyc < 60) begin
      i_ready = (cyc % 2 == 0);
      @(negedge clk);
      check("tog_valid", 32'(o_valid),    32'd1);
      check("tog_data",  o_data,          frm_c[k]);
      check("tog_last",  32'(o_last),     32'(k == DEPTH - 1));
      check("tog_rdy",   32'(o_in_ready), 32'((k == DEPTH - 1) && i_ready));
      check("tog_done",  32'(o_done),     32'd0);
      if (i_ready) k++;
      next_cycle();
      cyc++;
    end
    check("tog_beats", 32'(k), 32'(DEPTH));
    i_ready = 1'b1;
    check_done("tog");

    // Back-to-back: frame B loaded on A's final beat.
    start_load("b2b_a", frm_a);
    run_words("b2b_a", frm_a, 0, DEPTH - 1);
    i_load = 1'b1;
    i_data = frm_b;
    @(negedge clk);
    check("b2b_a12_data", o_data,          frm_a[DEPTH-1]);
    check("b2b_a12_last", 32'(o_last),     32'd1);
    check("b2b_a12_rdy",  32'(o_in_ready), 32'd1);
    next_cycle();
    i_load = 1'b0;
    @(negedge clk);
    check("b2b_b0_valid", 32'(o_valid), 32'd1);
    check("b2b_b0_data",  o_data,       frm_b[0]);
    check("b2b_b0_done",  32'(o_done),  32'd1);
    next_cycle();
    run_words("b2b_b", frm_b, 1, DEPTH);
    check_done("b2b_b");

    // Load attempt mid-frame with new data: ignored, frame continues intact.
    start_load("ign", frm_a);
    run_words("ign", frm_a, 0, 5);
    i_load = 1'b1;
    i_data = frm_b;
    @(negedge clk);
    check("ign_rdy",  32'(o_in_ready), 32'd0);
    check("ign_data", o_data,          frm_a[5]);
    next_cycle();
    i_load = 1'b0;
    run_words("ign", frm_a, 6, DEPTH);
    check_done("ign");

    // Reset at idx 7: immediate clear, no done, fresh load after release.
    start_load("rs", frm_a);
    run_words("rs", frm_a, 0, 7);
    #2;
    check("rs_pre_data", o_data, frm_a[7]);
    i_rst_n = 1'b0;
    #1;
    check("rs_valid", 32'(o_valid),    32'd0);
    check("rs_last",  32'(o_last),     32'd0);
    check("rs_data",  o_data,          32'd0);
    check("rs_done",  32'(o_done),     32'd0);
    check("rs_rdy",   32'(o_in_ready), 32'd1);
    @(negedge clk);
    check("rs_hold_done", 32'(o_done), 32'd0);
    next_cycle();
    i_rst_n = 1'b1;
    start_load("rs_b", frm_b);
    run_words("rs_b", frm_b, 0, DEPTH);
    check_done("rs_b");

    // Signed extremes pass through bit-exact.
    start_load("sgn", frm_s);
    run_words("sgn", frm_s, 0, DEPTH);
    check_done("sgn");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
